// File: rtl/interrupt_controller_n.sv
// rtl/interrupt_controller_n.sv - N-channel prioritised, nesting interrupt controller
module interrupt_controller_n #(
    parameter int          NUM_INT       = 2,
    parameter logic [15:0] VECTOR_BASE   = 16'h0004,
    parameter int          VECTOR_STRIDE = 4,
    parameter logic [7:0]  NMI_MASK      = 8'b01,
    parameter logic [7:0]  EDGE_MASK     = 8'b11,
    parameter int          SYNC_STAGES   = 2,
    parameter int          NEST_DEPTH    = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_INT-1:0] i_int,
    input  logic               i_fetch,
    input  logic               i_int_ack,
    input  logic               i_reti,
    input  logic               i_ei,
    input  logic               i_di,
    input  logic               i_mask_we,
    input  logic [NUM_INT-1:0] i_mask_din,
    output logic               o_int_req,
    output logic [15:0]        o_int_vector,
    output logic [2:0]         o_int_id,
    output logic [NUM_INT-1:0] o_in_service,
    output logic               o_gie
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    localparam logic [NUM_INT-1:0] L_NMI = NMI_MASK[NUM_INT-1:0];

    logic [SYNC_STAGES-1:0][NUM_INT-1:0] r_sync;
    logic [NUM_INT-1:0] r_sync_d;
    logic [NUM_INT-1:0] r_pending;
    logic [NUM_INT-1:0] r_in_service;
    logic [NUM_INT-1:0] r_ie_mask;
    logic               r_gie;
    state_t             r_state;
    logic [2:0]         r_id;
    logic [15:0]        r_vec;

    logic [NUM_INT-1:0] w_sync;
    logic [NUM_INT-1:0] w_edge;
    logic [NUM_INT-1:0] w_below;
    logic [NUM_INT-1:0] w_eligible;
    logic [NUM_INT-1:0] w_ack_clr;
    logic [NUM_INT-1:0] w_pending_nxt;
    logic [NUM_INT-1:0] w_is_reti;
    logic [NUM_INT-1:0] w_is_nxt;
    logic [3:0]         w_active_cnt;
    logic               w_depth_ok;
    logic               w_any;
    logic [2:0]         w_win_id;
    logic [15:0]        w_win_vec;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_ack;

    // Input synchroniser chain plus one delayed copy for rising-edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync   <= '0;
            r_sync_d <= '0;
        end else begin
            r_sync[0] <= i_int;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_sync_d <= w_sync;
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_edge = w_sync & ~r_sync_d;

    // Priority window below the lowest in-service channel and nesting occupancy
    always_comb begin
        w_below      = '0;
        w_active_cnt = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            w_below[i] = 1'b1;
            for (int j = 0; j <= i; j++) begin
                if (r_in_service[j]) begin
                    w_below[i] = 1'b0;
                end
            end
            w_active_cnt = w_active_cnt + 4'(r_in_service[i]);
        end
    end

    assign w_depth_ok = (w_active_cnt < 4'(NEST_DEPTH));
    assign w_eligible = r_pending
                      & (L_NMI | ({NUM_INT{r_gie}} & r_ie_mask))
                      & w_below
                      & {NUM_INT{w_depth_ok}};
    assign w_any      = |w_eligible;

    // Lowest eligible index wins; scan from the top so the lowest overwrites
    always_comb begin
        w_win_id = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_win_id = 3'(i);
            end
        end
    end

    assign w_win_vec = VECTOR_BASE + (16'(w_win_id) * 16'(VECTOR_STRIDE));

    // Request FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request FSM next state: sample at instruction boundary, hold until acknowledged
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_fetch && w_any) begin
                    w_state_nxt = S_REQ;
                    w_load      = 1'b1;
                end
            end
            S_REQ: begin
                if (i_int_ack) begin
                    w_state_nxt = S_IDLE;
                    w_ack       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One-hot of the acknowledged channel and next pending / in-service values
    always_comb begin
        w_ack_clr     = '0;
        w_pending_nxt = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            w_ack_clr[i] = w_ack && (r_id == 3'(i));
            if (EDGE_MASK[i]) begin
                w_pending_nxt[i] = (r_pending[i] & ~w_ack_clr[i]) | w_edge[i];
            end else begin
                w_pending_nxt[i] = w_sync[i];
            end
        end
    end

    // RETI retires the lowest set bit before any same-cycle ACK sets a new one
    assign w_is_reti = i_reti ? (r_in_service & (r_in_service - 1'b1)) : r_in_service;
    assign w_is_nxt  = w_is_reti | w_ack_clr;

    // Pending and in-service bookkeeping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending    <= '0;
            r_in_service <= '0;
        end else begin
            r_pending    <= w_pending_nxt;
            r_in_service <= w_is_nxt;
        end
    end

    // Global enable (DI dominates) and per-channel enable mask
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gie     <= 1'b0;
            r_ie_mask <= '1;
        end else begin
            if (i_di) begin
                r_gie <= 1'b0;
            end else if (i_ei) begin
                r_gie <= 1'b1;
            end
            if (i_mask_we) begin
                r_ie_mask <= i_mask_din;
            end
        end
    end

    // Winner id and vector frozen when the request is raised
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_id  <= '0;
            r_vec <= '0;
        end else if (w_load) begin
            r_id  <= w_win_id;
            r_vec <= w_win_vec;
        end
    end

    assign o_int_req    = (r_state == S_REQ);
    assign o_int_vector = r_vec;
    assign o_int_id     = r_id;
    assign o_in_service = r_in_service;
    assign o_gie        = r_gie;

endmodule

// File: tb/tb_interrupt_controller_n.sv
// tb/tb_interrupt_controller_n.sv - directed vector bench for interrupt_controller_n
module tb_interrupt_controller_n;

    logic clk;
    logic rst_n;

    logic [1:0]  a_int, a_mdin, a_is;
    logic        a_fetch, a_ack, a_reti, a_ei, a_di, a_mwe, a_req, a_gie;
    logic [15:0] a_vec;
    logic [2:0]  a_id;

    logic [3:0]  b_int, b_mdin, b_is;
    logic        b_fetch, b_ack, b_reti, b_ei, b_di, b_mwe, b_req, b_gie;
    logic [15:0] b_vec;
    logic [2:0]  b_id;

    int total = 0;
    int bad   = 0;

    interrupt_controller_n dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_int(a_int), .i_fetch(a_fetch),
        .i_int_ack(a_ack), .i_reti(a_reti), .i_ei(a_ei), .i_di(a_di),
        .i_mask_we(a_mwe), .i_mask_din(a_mdin), .o_int_req(a_req),
        .o_int_vector(a_vec), .o_int_id(a_id), .o_in_service(a_is), .o_gie(a_gie)
    );

    interrupt_controller_n #(
        .NUM_INT(4), .NMI_MASK(8'h00), .EDGE_MASK(8'hFF), .NEST_DEPTH(1)
    ) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_int(b_int), .i_fetch(b_fetch),
        .i_int_ack(b_ack), .i_reti(b_reti), .i_ei(b_ei), .i_di(b_di),
        .i_mask_we(b_mwe), .i_mask_din(b_mdin), .o_int_req(b_req),
        .o_int_vector(b_vec), .o_int_id(b_id), .o_in_service(b_is), .o_gie(b_gie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  pins;
        logic [5:0]  ctl;   // {fetch, ack, reti, ei, di, mask_we}
        logic [1:0]  mdin;
        logic        req;
        logic [15:0] vec;
        logic [2:0]  id;
        logic [1:0]  is;
        logic        gie;
    } vec_t;

    localparam logic [5:0] F = 6'b100000;
    localparam logic [5:0] A = 6'b010000;
    localparam logic [5:0] R = 6'b001000;
    localparam logic [5:0] E = 6'b000100;
    localparam logic [5:0] D = 6'b000010;
    localparam logic [5:0] W = 6'b000001;
    localparam logic [5:0] N = 6'b000000;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] p, logic [5:0] c, logic [1:0] md, logic er,
                                logic [15:0] ev, logic [2:0] eid, logic [1:0] eis, logic eg);
        vec_t v;
        v.pins = p; v.ctl = c; v.mdin = md; v.req = er;
        v.vec = ev; v.id = eid; v.is = eis; v.gie = eg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input bit sel, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if ((sel ? b_req : a_req) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        bit seen;

        rst_n = 1'b0;
        {a_int, a_mdin, a_fetch, a_ack, a_reti, a_ei, a_di, a_mwe} = '0;
        {b_int, b_mdin, b_fetch, b_ack, b_reti, b_ei, b_di, b_mwe} = '0;
        repeat (2) tick();
        rst_n = 1'b1;

        chk("rst_req", 16'(a_req), 16'd0);
        chk("rst_is", 16'(a_is), 16'd0);
        chk("rst_gie", 16'(a_gie), 16'd0);
        chk("rst_vec", a_vec, 16'h0000);
        chk("rst_id", 16'(a_id), 16'd0);

        // NMI ch0 with GIE=0
        tbl.push_back(mk(2'b01, N, 2'b00, 0, 16'h0, 0, 2'b00, 0));
        tbl.push_back(mk(2'b00, N, 2'b00, 0, 16'h0, 0, 2'b00, 0));
        tbl.push_back(mk(2'b00, N, 2'b00, 0, 16'h0, 0, 2'b00, 0));
        tbl.push_back(mk(2'b00, F, 2'b00, 1, 16'h0004, 0, 2'b00, 0));
        tbl.push_back(mk(2'b00, N, 2'b00, 1, 16'h0004, 0, 2'b00, 0));
        tbl.push_back(mk(2'b00, A, 2'b00, 0, 16'h0, 0, 2'b01, 0));
        tbl.push_back(mk(2'b00, R, 2'b00, 0, 16'h0, 0, 2'b00, 0));
        // maskable ch1 held until EI
        tbl.push_back(mk(2'b10, F, 2'b00, 0, 16'h0, 0, 2'b00, 0));
        tbl.push_back(mk(2'b10, F, 2'b00, 0, 16'h0, 0, 2'b00, 0));
        tbl.push_back(mk(2'b10, F, 2'b00, 0, 16'h0, 0, 2'b00, 0));
        tbl.push_back(mk(2'b10, F, 2'b00, 0, 16'h0, 0, 2'b00, 0));
        tbl.push_back(mk(2'b10, F|E, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b10, F, 2'b00, 1, 16'h0008, 1, 2'b00, 1));
        tbl.push_back(mk(2'b10, A, 2'b00, 0, 16'h0, 0, 2'b10, 1));
        tbl.push_back(mk(2'b10, R, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        // nesting: ch1 in service, ch0 preempts
        tbl.push_back(mk(2'b00, N, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b00, N, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b10, N, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b10, N, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b10, N, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b10, F, 2'b00, 1, 16'h0008, 1, 2'b00, 1));
        tbl.push_back(mk(2'b10, A, 2'b00, 0, 16'h0, 0, 2'b10, 1));
        tbl.push_back(mk(2'b11, N, 2'b00, 0, 16'h0, 0, 2'b10, 1));
        tbl.push_back(mk(2'b11, N, 2'b00, 0, 16'h0, 0, 2'b10, 1));
        tbl.push_back(mk(2'b11, N, 2'b00, 0, 16'h0, 0, 2'b10, 1));
        tbl.push_back(mk(2'b11, F, 2'b00, 1, 16'h0004, 0, 2'b10, 1));
        tbl.push_back(mk(2'b11, A, 2'b00, 0, 16'h0, 0, 2'b11, 1));
        tbl.push_back(mk(2'b11, R, 2'b00, 0, 16'h0, 0, 2'b10, 1));
        tbl.push_back(mk(2'b00, R, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b00, R, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        // GIE priority, ACK in IDLE ignored
        tbl.push_back(mk(2'b00, E|D, 2'b00, 0, 16'h0, 0, 2'b00, 0));
        tbl.push_back(mk(2'b00, E, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b00, D, 2'b00, 0, 16'h0, 0, 2'b00, 0));
        tbl.push_back(mk(2'b00, A, 2'b00, 0, 16'h0, 0, 2'b00, 0));
        // pending retained while masked
        tbl.push_back(mk(2'b00, E|W, 2'b01, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b10, N, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b10, N, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b10, N, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b10, F, 2'b00, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b10, F|W, 2'b11, 0, 16'h0, 0, 2'b00, 1));
        tbl.push_back(mk(2'b10, F, 2'b00, 1, 16'h0008, 1, 2'b00, 1));
        tbl.push_back(mk(2'b10, A, 2'b00, 0, 16'h0, 0, 2'b10, 1));
        tbl.push_back(mk(2'b00, R, 2'b00, 0, 16'h0, 0, 2'b00, 1));

        foreach (tbl[k]) begin
            a_int = tbl[k].pins;
            {a_fetch, a_ack, a_reti, a_ei, a_di, a_mwe} = tbl[k].ctl;
            a_mdin = tbl[k].mdin;
            tick();
            chk($sformatf("row%0d_req", k), 16'(a_req), 16'(tbl[k].req));
            chk($sformatf("row%0d_is", k), 16'(a_is), 16'(tbl[k].is));
            chk($sformatf("row%0d_gie", k), 16'(a_gie), 16'(tbl[k].gie));
            if (tbl[k].req) begin
                chk($sformatf("row%0d_vec", k), a_vec, tbl[k].vec);
                chk($sformatf("row%0d_id", k), 16'(a_id), 16'(tbl[k].id));
            end
        end
        {a_int, a_fetch, a_ack, a_reti, a_ei, a_di, a_mwe} = '0;

        // 4 channels, single nesting level: ch0 blocked while ch2 in service
        b_ei = 1'b1; tick(); b_ei = 1'b0;
        chk("b_gie", 16'(b_gie), 16'd1);
        b_int = 4'b0100; b_fetch = 1'b1;
        wait_req(1'b1, ok);
        chk("b_ch2_req", 16'(ok), 16'd1);
        chk("b_ch2_id", 16'(b_id), 16'd2);
        chk("b_ch2_vec", b_vec, 16'h000C);
        b_ack = 1'b1; tick(); b_ack = 1'b0;
        chk("b_ch2_is", 16'(b_is), 16'b0100);
        b_int = 4'b0101;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (b_req) seen = 1'b1;
        end
        chk("b_depth_block", 16'(seen), 16'd0);
        b_reti = 1'b1; tick(); b_reti = 1'b0;
        chk("b_reti_is", 16'(b_is), 16'b0000);
        wait_req(1'b1, ok);
        chk("b_ch0_req", 16'(ok), 16'd1);
        chk("b_ch0_vec", b_vec, 16'h0004);
        b_ack = 1'b1; tick(); b_ack = 1'b0;
        chk("b_ch0_is", 16'(b_is), 16'b0001);
        b_reti = 1'b1; tick(); b_reti = 1'b0;

        // same-cycle edges on ch1 and ch3
        b_int = 4'b0000;
        repeat (3) tick();
        b_int = 4'b1010;
        wait_req(1'b1, ok);
        chk("b_ch1_req", 16'(ok), 16'd1);
        chk("b_ch1_id", 16'(b_id), 16'd1);
        chk("b_ch1_vec", b_vec, 16'h0008);
        b_ack = 1'b1; tick(); b_ack = 1'b0;
        chk("b_ch1_is", 16'(b_is), 16'b0010);
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (b_req) seen = 1'b1;
        end
        chk("b_ch3_held", 16'(seen), 16'd0);
        b_reti = 1'b1; tick(); b_reti = 1'b0;
        wait_req(1'b1, ok);
        chk("b_ch3_req", 16'(ok), 16'd1);
        chk("b_ch3_id", 16'(b_id), 16'd3);
        chk("b_ch3_vec", b_vec, 16'h0010);
        b_ack = 1'b1; tick(); b_ack = 1'b0;
        chk("b_ch3_is", 16'(b_is), 16'b1000);
        b_fetch = 1'b0;

        // async reset while a request is outstanding
        a_int = 2'b10; a_fetch = 1'b1;
        wait_req(1'b0, ok);
        chk("a6_ch1_req", 16'(ok), 16'd1);
        a_ack = 1'b1; tick(); a_ack = 1'b0;
        chk("a6_ch1_is", 16'(a_is), 16'b10);
        a_int = 2'b11;
        wait_req(1'b0, ok);
        chk("a6_ch0_req", 16'(ok), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("a6_async_req", 16'(a_req), 16'd0);
        chk("a6_async_is", 16'(a_is), 16'd0);
        chk("a6_async_gie", 16'(a_gie), 16'd0);
        chk("a6_async_vec", a_vec, 16'h0000);
        chk("b6_async_is", 16'(b_is), 16'd0);
        {a_int, a_fetch} = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
